// File: rtl/pow_5_rr_scheduler_if.sv
// Requester, datapath and result buses of the pow_5 round-robin scheduler.
// slave = scheduler side, master = requester/datapath environment side.
interface pow_5_rr_scheduler_if #(
    parameter int width = 12,
    parameter int n_req = 4
);
    logic [n_req-1:0]       req_vld;
    logic [n_req*width-1:0] req_data;
    logic [n_req-1:0]       req_rdy;
    logic                   dp_vld;
    logic [width-1:0]       dp_data;
    logic                   dp_res_vld;
    logic [width-1:0]       dp_res_data;
    logic [n_req-1:0]       res_vld;
    logic [width-1:0]       res_data;

    modport slave (
        input  req_vld, req_data, dp_res_vld, dp_res_data,
        output req_rdy, dp_vld, dp_data, res_vld, res_data
    );

    modport master (
        output req_vld, req_data, dp_res_vld, dp_res_data,
        input  req_rdy, dp_vld, dp_data, res_vld, res_data
    );
endinterface

// File: rtl/pow_5_rr_scheduler.sv
// Round-robin share of one fixed-latency pow_5 datapath; grant->dp_vld 1 cycle, handshake->res_vld latency+2.
// Backpressure: en=0 stalls new grants only; results and datapath have no flow control, tag/result skew raises sticky err.
module pow_5_rr_scheduler #(
    parameter int width   = 12,
    parameter int n_req   = 4,
    parameter int latency = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    pow_5_rr_scheduler_if.slave  bus,
    output logic                 busy,
    output logic                 err
);
    localparam int idx_w = (n_req > 1) ? $clog2(n_req) : 1;
    localparam logic [idx_w-1:0] last_idx = idx_w'(n_req - 1);

    typedef struct packed {
        logic             vld;
        logic [idx_w-1:0] idx;
    } tag_t;

    logic [idx_w-1:0] ptr;
    logic             cand_vld;
    logic [idx_w-1:0] cand_idx;
    logic [idx_w-1:0] probe;
    logic             grant;
    logic             tags_any;

    // Stage 0 sits alongside dp_vld; stage 'latency' lines up with dp_res_vld.
    tag_t tag_q [0:latency];

    // Lowest offset from ptr wins, so scan from the far end and let nearer hits overwrite.
    always_comb begin
        cand_vld = 1'b0;
        cand_idx = '0;
        probe    = '0;
        for (int k = n_req - 1; k >= 0; k--) begin
            probe = idx_w'((int'(ptr) + k) % n_req);
            if (bus.req_vld[probe]) begin
                cand_vld = 1'b1;
                cand_idx = probe;
            end
        end
    end

    assign grant = en & cand_vld;

    always_comb begin
        bus.req_rdy = '0;
        if (grant) begin
            bus.req_rdy[cand_idx] = 1'b1;
        end
    end

    always_comb begin
        tags_any = 1'b0;
        for (int k = 0; k <= latency; k++) begin
            tags_any = tags_any | tag_q[k].vld;
        end
    end

    assign busy = bus.dp_vld | tags_any | (|bus.res_vld);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr          <= '0;
            bus.dp_vld   <= 1'b0;
            bus.dp_data  <= '0;
            bus.res_vld  <= '0;
            bus.res_data <= '0;
            err          <= 1'b0;
            for (int k = 0; k <= latency; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            bus.dp_vld <= grant;
            if (grant) begin
                bus.dp_data <= bus.req_data[cand_idx*width +: width];
                ptr         <= (cand_idx == last_idx) ? '0 : cand_idx + 1'b1;
            end

            tag_q[0] <= '{vld: grant, idx: cand_idx};
            for (int k = 1; k <= latency; k++) begin
                tag_q[k] <= tag_q[k-1];
            end

            bus.res_vld <= '0;
            if (tag_q[latency].vld && bus.dp_res_vld) begin
                bus.res_vld[tag_q[latency].idx] <= 1'b1;
                bus.res_data                    <= bus.dp_res_data;
            end

            // A slot with only one side valid means the datapath lost alignment; drop it.
            if (tag_q[latency].vld != bus.dp_res_vld) begin
                err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pow_5_rr_scheduler.sv
// Bench for pow_5_rr_scheduler: table-driven arbitration vectors, scoreboarded results, hand-written reset/mismatch sequences.
module tb_pow_5_rr_scheduler;
    localparam int width   = 12;
    localparam int n_req   = 4;
    localparam int latency = 4;
    localparam int nv      = 18;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic en    = 1'b0;
    logic busy;
    logic err;

    int tests = 0;
    int fails = 0;
    int dp_delay = latency;
    logic sb_push_en = 1'b1;

    always #5 clk = ~clk;

    pow_5_rr_scheduler_if #(.width(width), .n_req(n_req)) bus ();

    pow_5_rr_scheduler #(.width(width), .n_req(n_req), .latency(latency)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .bus   (bus),
        .busy  (busy),
        .err   (err)
    );

    function automatic logic [11:0] pow5(input logic [11:0] x);
        logic [23:0] r;
        r = 24'd1;
        for (int i = 0; i < 5; i++) begin
            r = 24'(r[11:0]) * 24'(x);
        end
        return r[11:0];
    endfunction

    // Ideal datapath, deliberately not reset so stale results survive a scheduler reset.
    logic        pv [0:7] = '{default: 1'b0};
    logic [11:0] pd [0:7] = '{default: 12'd0};

    always @(posedge clk) begin
        pv[0] <= bus.dp_vld;
        pd[0] <= pow5(bus.dp_data);
        for (int k = 1; k < 8; k++) begin
            pv[k] <= pv[k-1];
            pd[k] <= pd[k-1];
        end
    end

    assign bus.dp_res_vld  = pv[dp_delay-1];
    assign bus.dp_res_data = pd[dp_delay-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [3:0]  oh;
        logic [11:0] val;
    } exp_t;

    exp_t sb [$];

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && sb_push_en) begin
            for (int i = 0; i < n_req; i++) begin
                if (bus.req_vld[i] && bus.req_rdy[i]) begin
                    sb.push_back({bus.req_rdy, pow5(bus.req_data[i*width +: width])});
                end
            end
        end
        if (bus.res_vld != '0) begin
            if (sb.size() == 0) begin
                check("unexpected_res", 32'(bus.res_vld), 32'd0);
            end else begin
                e = sb.pop_front();
                check("sb_res_vld", 32'(bus.res_vld), 32'(e.oh));
                check("sb_res_data", 32'(bus.res_data), 32'(e.val));
            end
        end
    end

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 30) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(busy), 32'd0);
    endtask

    typedef struct {
        logic        en;
        logic [3:0]  vld;
        logic [47:0] data;
        logic [3:0]  exp_rdy;
    } vec_t;

    vec_t vecs [nv];

    initial begin
        logic [47:0] d_inc;
        logic [47:0] d_alt;
        d_inc = {12'd4, 12'd3, 12'd2, 12'd1};
        d_alt = {12'd9, 12'd10, 12'd11, 12'd7};

        // Pointer fairness, entered with ptr=2 after the single-op sequence.
        vecs[0]  = '{1'b1, 4'b0100, d_alt, 4'b0100};
        vecs[1]  = '{1'b1, 4'b1001, d_alt, 4'b1000};
        vecs[2]  = '{1'b1, 4'b1001, d_alt, 4'b0001};
        vecs[3]  = '{1'b1, 4'b1000, d_alt, 4'b1000};
        // Full contention from ptr=0.
        for (int i = 0; i < 8; i++) begin
            vecs[4+i] = '{1'b1, 4'b1111, d_inc, 4'(1 << (i % 4))};
        end
        // Three ops in flight, then en=0 must block everything.
        vecs[12] = '{1'b1, 4'b0111, d_inc, 4'b0001};
        vecs[13] = '{1'b1, 4'b0110, d_inc, 4'b0010};
        vecs[14] = '{1'b1, 4'b0100, d_inc, 4'b0100};
        vecs[15] = '{1'b0, 4'b1111, d_inc, 4'b0000};
        vecs[16] = '{1'b0, 4'b1111, d_inc, 4'b0000};
        vecs[17] = '{1'b0, 4'b1111, d_inc, 4'b0000};

        bus.req_vld  = '0;
        bus.req_data = '0;
        #2;
        rst_n = 1'b0;

        en           = 1'b1;
        bus.req_vld  = 4'b1111;
        bus.req_data = d_inc;
        repeat (3) @(negedge clk);
        check("rst_req_rdy", 32'(bus.req_rdy), 32'b0001);
        check("rst_dp_vld", 32'(bus.dp_vld), 32'd0);
        check("rst_dp_data", 32'(bus.dp_data), 32'd0);
        check("rst_res_vld", 32'(bus.res_vld), 32'd0);
        check("rst_res_data", 32'(bus.res_data), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_first_grant", 32'(bus.req_rdy), 32'b0001);
        @(posedge clk); #1;
        bus.req_vld = '0;
        wait_idle("rst_idle");

        @(posedge clk); #1;
        bus.req_vld  = 4'b0010;
        bus.req_data = {12'd0, 12'd0, 12'd3, 12'd0};
        @(negedge clk);
        check("single_rdy", 32'(bus.req_rdy), 32'b0010);
        @(posedge clk); #1;
        bus.req_vld = '0;
        @(negedge clk);
        check("single_dp_vld", 32'(bus.dp_vld), 32'd1);
        check("single_dp_data", 32'(bus.dp_data), 32'd3);
        repeat (4) @(negedge clk);
        check("single_res_early", 32'(bus.res_vld), 32'd0);
        @(negedge clk);
        check("single_res_vld", 32'(bus.res_vld), 32'b0010);
        check("single_res_data", 32'(bus.res_data), 32'd243);
        @(negedge clk);
        check("single_busy", 32'(busy), 32'd0);

        for (int i = 0; i < nv; i++) begin
            @(posedge clk); #1;
            en           = vecs[i].en;
            bus.req_vld  = vecs[i].vld;
            bus.req_data = vecs[i].data;
            @(negedge clk);
            check($sformatf("vec%0d_rdy", i), 32'(bus.req_rdy), 32'(vecs[i].exp_rdy));
        end
        @(posedge clk); #1;
        bus.req_vld = '0;
        en          = 1'b1;
        wait_idle("vec_idle");
        check("vec_err", 32'(err), 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);

        // Datapath one cycle slower than the tag pipe: every slot mismatches.
        dp_delay   = 5;
        sb_push_en = 1'b0;
        @(posedge clk); #1;
        bus.req_vld  = 4'b0001;
        bus.req_data = d_inc;
        @(negedge clk);
        check("mm_rdy", 32'(bus.req_rdy), 32'b0001);
        @(posedge clk); #1;
        bus.req_vld = '0;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            check($sformatf("mm_no_res%0d", i), 32'(bus.res_vld), 32'd0);
            if (i == 5) check("mm_err_before", 32'(err), 32'd0);
            if (i == 6) check("mm_err_set", 32'(err), 32'd1);
        end

        @(posedge clk); #1;
        bus.req_vld = 4'b0011;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.req_vld = '0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("rr_err_clear", 32'(err), 32'd0);
        check("rr_busy_clear", 32'(busy), 32'd0);
        check("rr_dp_vld", 32'(bus.dp_vld), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rr_err_post", 32'(err), 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("rr_no_res%0d", i), 32'(bus.res_vld), 32'd0);
        end
        check("rr_stale_err", 32'(err), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pow_5_rr_scheduler.md
Name: pow_5_rr_scheduler

Overview:
- Shares one fixed-latency, no-flow-control pow_5 datapath among n_req requesters.
- Arbitrates round-robin and issues at most one operand per cycle.
- Tracks each in-flight operation's requester index in a tag shift register, then routes the returned result to the owning requester.
- Sits between the key/switch-driven requester logic and the pow_5 datapath instance in the lab top.

Parameters:
width, 12, operand/result bit width
n_req, 4, number of requesters (2..8)
latency, 4, fixed datapath latency in cycles, dp_vld to dp_res_vld (>=1)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  grant enable; 0 blocks new grants, in-flight work still completes
req_vld  input  n_req  per-requester operand valid
req_data  input  n_req*width  operands, requester i at [i*width +: width]
req_rdy  output  n_req  one-hot grant; transfer when req_vld[i] & req_rdy[i]
dp_vld  output  1  operand valid to datapath
dp_data  output  width  operand to datapath
dp_res_vld  input  1  result valid from datapath
dp_res_data  input  width  result from datapath
res_vld  output  n_req  one-hot result strobe per requester, no backpressure
res_data  output  width  result value, meaningful when res_vld != 0
busy  output  1  any operation in flight
err  output  1  sticky tag/result mismatch flag

Behaviour:
- Reset (rst_n=0, asynchronous):
  - dp_vld, dp_data, res_vld, res_data, err, busy = 0.
  - All tag entries invalid.
  - RR pointer = 0, meaning requester 0 has highest priority.
- Reset mid-operation discards all in-flight tags. Results arriving after reset deasserts with no matching tag set err (see mismatch rule).
- Arbitration (combinational, same cycle):
  - When en=1, req_rdy = one-hot of the first requester with req_vld=1, searching from ptr upward with wrap modulo n_req.
  - req_rdy = 0 when en=0 or no req_vld.
  - req_rdy depends on req_vld; requesters must not make req_vld depend on req_rdy.
- Pointer update: on a grant to index g, ptr <= (g+1) mod n_req. No grant leaves ptr unchanged.
- Issue (registered):
  - Cycle after a grant: dp_vld=1, dp_data = granted operand.
  - Tag {1, g} enters stage 0 of the tag shift register.
  - No grant: dp_vld=0, dp_data holds its previous value, and an invalid tag enters.
- Tag shift register:
  - Depth = latency, advances every cycle.
  - The tail entry aligns with dp_res_vld exactly latency cycles after the matching dp_vld.
- Return (registered, one cycle after dp_res_vld):
  - Tail valid and dp_res_vld=1: res_vld = one-hot(tail idx), res_data = dp_res_data.
  - Otherwise res_vld = 0 and res_data holds.
- Total latency from a req handshake to res_vld = latency + 2 cycles.
- Mismatch:
  - Tail valid with dp_res_vld=0, or dp_res_vld=1 with tail invalid: err <= 1, and no res_vld is produced for that slot.
  - err clears only on reset.
- busy = dp_vld OR any tag entry valid OR any res_vld bit set.
- Throughput: one grant per cycle sustained. Over any n_req consecutive grants with all requesters continuously valid, each requester is granted exactly once.
- The scheduler does no arithmetic on data; width wrap of results is the datapath's responsibility.
- Simultaneous grant and return in the same cycle are independent and both proceed.

Test Plan:
Bench setup: width=12, n_req=4, latency=4; the datapath model is ideal x^5 mod 4096, delayed 4 cycles.
- Reset: hold rst_n=0 with all req_vld=1 -> req_rdy still combinationally one-hot 0001 while en=1; all registered outputs 0, err=0, busy=0; on release, first grant goes to requester 0.
- Single op: req_vld=0010, data[1]=3, one cycle -> req_rdy=0010; dp_vld=1 with dp_data=3 next cycle; 6 cycles after the handshake, res_vld=0010 and res_data=243; then busy=0.
- Full contention: req_vld=1111 for 8 cycles, data=i+1 -> grants 0,1,2,3,0,1,2,3; results 1, 32, 243, 1024 repeat with matching res_vld one-hots; err=0.
- Pointer fairness: grant to 2, then req_vld=1001 -> grant 3 first, then 0; ptr wraps correctly.
- en gating: with 3 ops in flight drive en=0 and req_vld=1111 -> req_rdy=0; all 3 results still delivered; busy drops.
- Mismatch and reset: the datapath model is delayed 5 cycles (one more than latency=4) -> err=1 and results are dropped. Pulse rst_n low mid-flight -> err=0, tags cleared; any stale dp_res_vld afterwards sets err and produces no res_vld.
